// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline control slice
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - pipeline status in, register enables/flushes/forwarding out
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic             uses_rt_ID;
    logic             jump_ID;
    logic             memRead_EX;
    logic [4:0]       dest_EX;
    logic [4:0]       rs_EX;
    logic [4:0]       rt_EX;
    logic             branch_taken_EX;
    logic             Reg_Write_MEM;
    logic [4:0]       dest_MEM;
    logic             Reg_Write_WB;
    logic [4:0]       dest_WB;
    logic             dmem_busy;

    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_write;
    logic             IDEX_flush;
    logic             EXMEM_write;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output rs_ID, rt_ID, uses_rt_ID, jump_ID, memRead_EX, dest_EX, rs_EX, rt_EX,
               branch_taken_EX, Reg_Write_MEM, dest_MEM, Reg_Write_WB, dest_WB, dmem_busy,
        input  PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_write,
               forwardA, forwardB, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  rs_ID, rt_ID, uses_rt_ID, jump_ID, memRead_EX, dest_EX, rs_EX, rt_EX,
               branch_taken_EX, Reg_Write_MEM, dest_MEM, Reg_Write_WB, dest_WB, dmem_busy,
        output PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_write,
               forwardA, forwardB, stall_cnt, flush_cnt, mem_timeout
    );

endinterface

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX operand forwarding select for one source register
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       i_reg_write_mem,
    input  logic [4:0] i_dest_mem,
    input  logic       i_reg_write_wb,
    input  logic [4:0] i_dest_wb,
    input  logic [4:0] i_src,
    output logic [1:0] o_fwd
);

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        o_fwd = FWD_RF;
        if (i_reg_write_mem && (i_dest_mem != 5'd0) && (i_dest_mem == i_src)) begin
            o_fwd = FWD_MEM;
        end else if (i_reg_write_wb && (i_dest_wb != 5'd0) && (i_dest_wb == i_src)) begin
            o_fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - load-use stall, branch/jump squash, memory freeze and forwarding
module hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_sequencer_if.slave  bus
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               r_mem_timeout;

    logic               w_load_use;
    logic [WAIT_W-1:0]  w_wait_inc;
    logic               w_pc_write, w_ifid_write, w_idex_write, w_exmem_write;
    logic               w_ifid_flush, w_idex_flush;
    logic               w_stall_ev, w_flush_ev, w_stall_start;
    logic [1:0]         w_fwd_a, w_fwd_b;

    assign w_load_use = bus.memRead_EX && (bus.dest_EX != 5'd0) &&
                        ((bus.dest_EX == bus.rs_ID) ||
                         (bus.uses_rt_ID && (bus.dest_EX == bus.rt_ID)));

    assign w_wait_inc = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_write  = 1'b1;
        w_exmem_write = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_stall_ev    = 1'b0;
        w_flush_ev    = 1'b0;
        w_stall_start = 1'b0;
        if (rst) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (bus.dmem_busy) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_write = 1'b0;
            w_stall_ev    = 1'b1;
        end else if (bus.branch_taken_EX) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_flush_ev   = 1'b1;
        end else if (w_load_use && (r_state != LOAD_STALL)) begin
            // In LOAD_STALL the bubble already separates load and consumer
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_flush  = 1'b1;
            w_stall_ev    = 1'b1;
            w_stall_start = 1'b1;
        end else if (bus.jump_ID) begin
            w_ifid_flush = 1'b1;
            w_flush_ev   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (bus.dmem_busy) begin
                r_state    <= MEM_WAIT;
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == WAIT_MAX) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
                r_state    <= w_stall_start ? LOAD_STALL : RUN;
            end
            if (w_stall_ev && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_ev && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    forward_unit u_fwd_a (
        .i_reg_write_mem (bus.Reg_Write_MEM),
        .i_dest_mem      (bus.dest_MEM),
        .i_reg_write_wb  (bus.Reg_Write_WB),
        .i_dest_wb       (bus.dest_WB),
        .i_src           (bus.rs_EX),
        .o_fwd           (w_fwd_a)
    );

    forward_unit u_fwd_b (
        .i_reg_write_mem (bus.Reg_Write_MEM),
        .i_dest_mem      (bus.dest_MEM),
        .i_reg_write_wb  (bus.Reg_Write_WB),
        .i_dest_wb       (bus.dest_WB),
        .i_src           (bus.rt_EX),
        .o_fwd           (w_fwd_b)
    );

    assign bus.PC_write    = w_pc_write;
    assign bus.IFID_write  = w_ifid_write;
    assign bus.IFID_flush  = w_ifid_flush;
    assign bus.IDEX_write  = w_idex_write;
    assign bus.IDEX_flush  = w_idex_flush;
    assign bus.EXMEM_write = w_exmem_write;
    assign bus.forwardA    = rst ? FWD_RF : w_fwd_a;
    assign bus.forwardB    = rst ? FWD_RF : w_fwd_b;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
    assign bus.mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed bench for hazard_sequencer
module tb_hazard_sequencer;

    // {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush}
    localparam logic [5:0] C_RUN   = 6'b111100;
    localparam logic [5:0] C_RST   = 6'b001111;
    localparam logic [5:0] C_STALL = 6'b001101;
    localparam logic [5:0] C_BR    = 6'b111111;
    localparam logic [5:0] C_JMP   = 6'b111110;
    localparam logic [5:0] C_WAIT  = 6'b000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] ctrl;

    hazard_sequencer_if #(.CNT_W(16)) bus ();

    hazard_sequencer #(.MAX_WAIT(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign ctrl = {bus.PC_write, bus.IFID_write, bus.IDEX_write, bus.EXMEM_write,
                   bus.IFID_flush, bus.IDEX_flush};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.rs_ID = 5'd0;           bus.rt_ID = 5'd0;
        bus.uses_rt_ID = 1'b0;      bus.jump_ID = 1'b0;
        bus.memRead_EX = 1'b0;      bus.dest_EX = 5'd0;
        bus.rs_EX = 5'd0;           bus.rt_EX = 5'd0;
        bus.branch_taken_EX = 1'b0; bus.Reg_Write_MEM = 1'b0;
        bus.dest_MEM = 5'd0;        bus.Reg_Write_WB = 1'b0;
        bus.dest_WB = 5'd0;         bus.dmem_busy = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        bus.Reg_Write_MEM = 1'b1; bus.dest_MEM = 5'd5; bus.rs_EX = 5'd5;
        #1;
        n_cmp++; if (ctrl !== C_RST) begin n_bad++; $display("FAIL rst_ctrl: got %b want %b", ctrl, C_RST); end
        n_cmp++; if (bus.forwardA !== 2'b00) begin n_bad++; $display("FAIL rst_fwdA: got %b want 00", bus.forwardA); end
        tick();
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_stall_cnt: got %0d want 0", bus.stall_cnt); end
        n_cmp++; if (bus.flush_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_flush_cnt: got %0d want 0", bus.flush_cnt); end
        n_cmp++; if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", bus.mem_timeout); end
        rst = 1'b0;
        clear_inputs();
        #1;
        n_cmp++; if (ctrl !== C_RUN) begin n_bad++; $display("FAIL run_ctrl: got %b want %b", ctrl, C_RUN); end
    endtask

    task automatic test_load_use;
        bus.memRead_EX = 1'b1; bus.dest_EX = 5'd8; bus.rs_ID = 5'd8;
        #1;
        n_cmp++; if (ctrl !== C_STALL) begin n_bad++; $display("FAIL lu_stall: got %b want %b", ctrl, C_STALL); end
        tick();
        n_cmp++; if (ctrl !== C_RUN) begin n_bad++; $display("FAIL lu_one_bubble: got %b want %b", ctrl, C_RUN); end
        n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d want 1", bus.stall_cnt); end
        tick();
        bus.rs_ID = 5'd3; bus.rt_ID = 5'd8; bus.uses_rt_ID = 1'b0;
        #1;
        n_cmp++; if (ctrl !== C_RUN) begin n_bad++; $display("FAIL lu_rt_unused: got %b want %b", ctrl, C_RUN); end
        bus.uses_rt_ID = 1'b1;
        #1;
        n_cmp++; if (ctrl !== C_STALL) begin n_bad++; $display("FAIL lu_rt_used: got %b want %b", ctrl, C_STALL); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (bus.stall_cnt !== 16'd2) begin n_bad++; $display("FAIL lu_rt_stall_cnt: got %0d want 2", bus.stall_cnt); end
        tick();
    endtask

    task automatic test_zero_reg;
        bus.memRead_EX = 1'b1; bus.dest_EX = 5'd0; bus.rs_ID = 5'd0;
        bus.Reg_Write_MEM = 1'b1; bus.dest_MEM = 5'd0; bus.rs_EX = 5'd0;
        #1;
        n_cmp++; if (ctrl !== C_RUN) begin n_bad++; $display("FAIL zero_no_stall: got %b want %b", ctrl, C_RUN); end
        n_cmp++; if (bus.forwardA !== 2'b00) begin n_bad++; $display("FAIL zero_fwdA: got %b want 00", bus.forwardA); end
        tick();
        clear_inputs();
    endtask

    task automatic test_forward;
        bus.Reg_Write_MEM = 1'b1; bus.dest_MEM = 5'd5;
        bus.Reg_Write_WB = 1'b1;  bus.dest_WB = 5'd5;
        bus.rs_EX = 5'd5; bus.rt_EX = 5'd5;
        #1;
        n_cmp++; if (bus.forwardA !== 2'b10) begin n_bad++; $display("FAIL fwd_mem_A: got %b want 10", bus.forwardA); end
        n_cmp++; if (bus.forwardB !== 2'b10) begin n_bad++; $display("FAIL fwd_mem_B: got %b want 10", bus.forwardB); end
        bus.Reg_Write_MEM = 1'b0;
        #1;
        n_cmp++; if (bus.forwardA !== 2'b01) begin n_bad++; $display("FAIL fwd_wb_A: got %b want 01", bus.forwardA); end
        n_cmp++; if (bus.forwardB !== 2'b01) begin n_bad++; $display("FAIL fwd_wb_B: got %b want 01", bus.forwardB); end
        bus.rt_EX = 5'd6;
        #1;
        n_cmp++; if (bus.forwardB !== 2'b00) begin n_bad++; $display("FAIL fwd_none_B: got %b want 00", bus.forwardB); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_over_load_use;
        bus.branch_taken_EX = 1'b1;
        bus.memRead_EX = 1'b1; bus.dest_EX = 5'd8; bus.rs_ID = 5'd8;
        #1;
        n_cmp++; if (ctrl !== C_BR) begin n_bad++; $display("FAIL br_ctrl: got %b want %b", ctrl, C_BR); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (bus.flush_cnt !== 16'd1) begin n_bad++; $display("FAIL br_flush_cnt: got %0d want 1", bus.flush_cnt); end
        n_cmp++; if (bus.stall_cnt !== 16'd2) begin n_bad++; $display("FAIL br_stall_cnt: got %0d want 2", bus.stall_cnt); end
        n_cmp++; if (ctrl !== C_RUN) begin n_bad++; $display("FAIL br_after: got %b want %b", ctrl, C_RUN); end
    endtask

    task automatic test_jump;
        bus.jump_ID = 1'b1;
        #1;
        n_cmp++; if (ctrl !== C_JMP) begin n_bad++; $display("FAIL jmp_ctrl: got %b want %b", ctrl, C_JMP); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (bus.flush_cnt !== 16'd2) begin n_bad++; $display("FAIL jmp_flush_cnt: got %0d want 2", bus.flush_cnt); end
    endtask

    task automatic test_mem_wait;
        bus.branch_taken_EX = 1'b1;
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ctrl !== C_WAIT) begin n_bad++; $display("FAIL wait_ctrl[%0d]: got %b want %b", i, ctrl, C_WAIT); end
            tick();
        end
        bus.dmem_busy = 1'b0;
        #1;
        n_cmp++; if (ctrl !== C_BR) begin n_bad++; $display("FAIL wait_redirect: got %b want %b", ctrl, C_BR); end
        n_cmp++; if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL wait_no_timeout: got %b want 0", bus.mem_timeout); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (bus.flush_cnt !== 16'd3) begin n_bad++; $display("FAIL wait_flush_cnt: got %0d want 3", bus.flush_cnt); end
        n_cmp++; if (bus.stall_cnt !== 16'd5) begin n_bad++; $display("FAIL wait_stall_cnt: got %0d want 5", bus.stall_cnt); end
    endtask

    task automatic test_busy_then_load_use;
        bus.memRead_EX = 1'b1; bus.dest_EX = 5'd9; bus.rs_ID = 5'd9;
        bus.dmem_busy = 1'b1;
        #1;
        n_cmp++; if (ctrl !== C_WAIT) begin n_bad++; $display("FAIL busy_lu_hold: got %b want %b", ctrl, C_WAIT); end
        tick();
        bus.dmem_busy = 1'b0;
        #1;
        n_cmp++; if (ctrl !== C_STALL) begin n_bad++; $display("FAIL busy_lu_release: got %b want %b", ctrl, C_STALL); end
        tick();
        clear_inputs();
        #1;
        n_cmp++; if (bus.stall_cnt !== 16'd7) begin n_bad++; $display("FAIL busy_lu_stall_cnt: got %0d want 7", bus.stall_cnt); end
        tick();
    endtask

    task automatic test_timeout_and_reset;
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.dmem_busy = 1'b0;
        #1;
        n_cmp++; if (bus.mem_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_set: got %b want 1", bus.mem_timeout); end
        tick();
        tick();
        n_cmp++; if (bus.mem_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", bus.mem_timeout); end
        n_cmp++; if (bus.stall_cnt !== 16'd11) begin n_bad++; $display("FAIL timeout_stall_cnt: got %0d want 11", bus.stall_cnt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.mem_timeout !== 1'b0) begin n_bad++; $display("FAIL clr_timeout: got %b want 0", bus.mem_timeout); end
        n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_stall_cnt: got %0d want 0", bus.stall_cnt); end
        n_cmp++; if (bus.flush_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_flush_cnt: got %0d want 0", bus.flush_cnt); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_forward();
        test_branch_over_load_use();
        test_jump();
        test_mem_wait();
        test_busy_then_load_use();
        test_timeout_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
